// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: fetch sequencer between the PC/redirect logic, the ICache
// and the instruction buffer. It keeps at most one ICache request outstanding,
// forwards returned instruction pairs combinationally, throttles on
// buffer-full and squashes in-flight responses after a redirect.
//
// Handshake semantics (single statement for all interfaces):
//   request  : a request is accepted in a cycle where icache_req_o && icache_ack_i;
//              icache_ack_i is ignored whenever icache_req_o is low.
//   response : icache_resp_valid_i for one cycle delivers the data of the single
//              outstanding request; it is never back-pressured.
//   push     : inst1_valid_o / inst2_valid_o are one-cycle push strobes; the
//              buffer always has room for the pair already in flight.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int          LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        buffer_full_i,
  output logic        icache_req_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_ack_i,
  input  logic        icache_resp_valid_i,
  input  logic [31:0] icache_inst1_i,
  input  logic [31:0] icache_inst2_i,
  output logic [31:0] inst1_o,
  output logic [31:0] inst2_o,
  output logic [31:0] inst1_addr_o,
  output logic [31:0] inst2_addr_o,
  output logic        inst1_valid_o,
  output logic        inst2_valid_o,
  output logic [15:0] discard_cnt_o,
  output logic [1:0]  state_dbg_o
);

  localparam int LW_BITS = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;

  logic        req;
  logic        v1;
  logic        v2;
  logic        last_word;
  logic        fwd;
  logic [15:0] cnt_inc;
  logic        unused_flush_lsbs;

  // Redirect targets are word aligned; the low bits carry no information.
  assign unused_flush_lsbs = ^flush_pc_i[1:0];

  // Second word of the pair falls into the next line when pc is the line's last word.
  assign last_word = &pc_q[LW_BITS+1:2];

  // Saturating increment for the squashed-response counter.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // State, pc and discard counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, pc update and request/push decisions; flush overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    v1      = 1'b0;
    v2      = 1'b0;
    if (flush_i) begin
      pc_d = {flush_pc_i[31:2], 2'b00};
      case (state_q)
        S_WAIT, S_DISCARD: begin
          if (icache_resp_valid_i) begin
            cnt_d   = cnt_inc;
            state_d = S_REQ;
          end else begin
            state_d = S_DISCARD;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          req = !buffer_full_i;
          if (req && icache_ack_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (icache_resp_valid_i) begin
            v1      = 1'b1;
            v2      = !last_word;
            pc_d    = pc_q + (last_word ? 32'd4 : 32'd8);
            state_d = S_REQ;
          end
        end
        S_DISCARD: begin
          if (icache_resp_valid_i) begin
            cnt_d   = cnt_inc;
            state_d = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Data and addresses pass through only while a response is awaited.
  assign fwd = (state_q == S_WAIT) && !rst;

  assign icache_req_o  = req && !rst;
  assign icache_pc_o   = pc_q;
  assign inst1_valid_o = v1 && !rst;
  assign inst2_valid_o = v2 && !rst;
  assign inst1_o       = fwd ? icache_inst1_i : 32'd0;
  assign inst2_o       = fwd ? icache_inst2_i : 32'd0;
  assign inst1_addr_o  = fwd ? pc_q : 32'd0;
  assign inst2_addr_o  = fwd ? pc_q + 32'd4 : 32'd0;
  assign discard_cnt_o = rst ? 16'd0 : cnt_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Randomized bench for inst_fetch_ctrl with a transaction-level reference model
// (pending / squashed flags) and a behavioural ICache with random latency.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
  localparam int          LINE_WORDS = 8;
  localparam int          N_CYCLES   = 6000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        buffer_full_i;
  logic        icache_req_o;
  logic [31:0] icache_pc_o;
  logic        icache_ack_i;
  logic        icache_resp_valid_i;
  logic [31:0] icache_inst1_i;
  logic [31:0] icache_inst2_i;
  logic [31:0] inst1_o;
  logic [31:0] inst2_o;
  logic [31:0] inst1_addr_o;
  logic [31:0] inst2_addr_o;
  logic        inst1_valid_o;
  logic        inst2_valid_o;
  logic [15:0] discard_cnt_o;
  logic [1:0]  state_dbg_o;

  inst_fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .flush_i            (flush_i),
    .flush_pc_i         (flush_pc_i),
    .buffer_full_i      (buffer_full_i),
    .icache_req_o       (icache_req_o),
    .icache_pc_o        (icache_pc_o),
    .icache_ack_i       (icache_ack_i),
    .icache_resp_valid_i(icache_resp_valid_i),
    .icache_inst1_i     (icache_inst1_i),
    .icache_inst2_i     (icache_inst2_i),
    .inst1_o            (inst1_o),
    .inst2_o            (inst2_o),
    .inst1_addr_o       (inst1_addr_o),
    .inst2_addr_o       (inst2_addr_o),
    .inst1_valid_o      (inst1_valid_o),
    .inst2_valid_o      (inst2_valid_o),
    .discard_cnt_o      (discard_cnt_o),
    .state_dbg_o        (state_dbg_o)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ic_data(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  function automatic bit last_in_line(input logic [31:0] a);
    return ((a >> 2) % LINE_WORDS) == (LINE_WORDS - 1);
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  bit          m_active;   // left the post-reset idle cycle
  bit          m_pending;  // a request was accepted, response not yet seen
  bit          m_stale;    // the pending response belongs to a squashed path
  bit          m_pc_known;

  // behavioural ICache
  bit          ic_busy;
  int          ic_wait;
  logic [31:0] ic_addr;

  logic [31:0] fpcs[6];

  // ---------------- driver + checker loop ----------------
  initial begin
    bit          e_req, e_v1, e_v2, e_zero, accepted;
    logic [31:0] fpc_al;

    fpcs = '{32'h0000_2003, 32'hFFFF_FFF8, 32'hBFC0_001C,
             32'h0000_0100, 32'hFFFF_FFFC, 32'h1234_5678};
    m_pc = RESET_PC; m_cnt = 16'd0; m_active = 0; m_pending = 0; m_stale = 0;
    m_pc_known = 0; ic_busy = 0; ic_wait = 0; ic_addr = 32'd0;
    rst = 1'b1; flush_i = 1'b0; flush_pc_i = 32'd0; buffer_full_i = 1'b0;
    icache_ack_i = 1'b0; icache_resp_valid_i = 1'b0;
    icache_inst1_i = 32'd0; icache_inst2_i = 32'd0;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      rst        = (cyc < 2) || ($urandom_range(0, 299) == 0);
      flush_i    = ($urandom_range(0, 11) == 0);
      flush_pc_i = ($urandom_range(0, 1) == 1) ? fpcs[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 5) == 0) buffer_full_i = ~buffer_full_i;
      icache_ack_i        = ($urandom_range(0, 1) == 1);
      icache_resp_valid_i = ic_busy && (ic_wait == 0);
      icache_inst1_i      = ic_data(ic_addr);
      icache_inst2_i      = ic_data(ic_addr + 32'd4);
      fpc_al = {flush_pc_i[31:2], 2'b00};
      #1;

      // expected outputs this cycle
      e_req = 0; e_v1 = 0; e_v2 = 0;
      e_zero = rst || !m_active;
      if (!rst && m_active) begin
        if (!m_pending) e_req = !buffer_full_i && !flush_i;
        else if (!m_stale && icache_resp_valid_i && !flush_i) begin
          e_v1 = 1;
          e_v2 = !last_in_line(m_pc);
        end
      end

      check_val("req", {31'd0, icache_req_o}, {31'd0, e_req});
      check_val("v1", {31'd0, inst1_valid_o}, {31'd0, e_v1});
      check_val("v2", {31'd0, inst2_valid_o}, {31'd0, e_v2});
      check_val("discard_cnt", {16'd0, discard_cnt_o}, {16'd0, (rst ? 16'd0 : m_cnt)});
      if (m_pc_known) check_val("icache_pc", icache_pc_o, m_pc);
      if (e_v1) begin
        exp_q.push_back(m_pc);
        exp_q.push_back(ic_data(m_pc));
        check_val("addr1", inst1_addr_o, exp_q.pop_front());
        check_val("inst1", inst1_o, exp_q.pop_front());
      end
      if (e_v2) begin
        exp_q.push_back(m_pc + 32'd4);
        exp_q.push_back(ic_data(m_pc + 32'd4));
        check_val("addr2", inst2_addr_o, exp_q.pop_front());
        check_val("inst2", inst2_o, exp_q.pop_front());
      end
      if (e_zero) begin
        check_val("idle_addr1", inst1_addr_o, 32'd0);
        check_val("idle_addr2", inst2_addr_o, 32'd0);
        check_val("idle_inst1", inst1_o, 32'd0);
        check_val("idle_inst2", inst2_o, 32'd0);
      end

      // advance the model to the next cycle
      accepted = e_req && icache_ack_i;
      if (rst) begin
        m_pc = RESET_PC; m_cnt = 16'd0; m_active = 0; m_pending = 0; m_stale = 0;
        m_pc_known = 1; ic_busy = 0; ic_wait = 0;
      end else begin
        if (icache_resp_valid_i) ic_busy = 0;
        else if (ic_busy) ic_wait--;
        if (accepted) begin
          ic_busy = 1;
          ic_wait = $urandom_range(0, 3);
          ic_addr = m_pc;
        end
        if (!m_active) begin
          m_active = 1;
          if (flush_i) m_pc = fpc_al;
        end else if (!m_pending) begin
          if (flush_i) m_pc = fpc_al;
          else if (accepted) m_pending = 1;
        end else if (!m_stale) begin
          if (flush_i) begin
            m_pc = fpc_al;
            if (icache_resp_valid_i) begin
              if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
              m_pending = 0;
            end else begin
              m_stale = 1;
            end
          end else if (icache_resp_valid_i) begin
            m_pc = m_pc + (e_v2 ? 32'd8 : 32'd4);
            m_pending = 0;
          end
        end else begin
          if (flush_i) m_pc = fpc_al;
          if (icache_resp_valid_i) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_pending = 0;
            m_stale = 0;
          end
        end
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Fetch sequencer between the PC/branch-redirect logic, the ICache and the instruction buffer. It owns the fetch PC and issues one ICache request at a time, with at most one outstanding. Returned instruction pairs are forwarded to the buffer's push port, and the block throttles on buffer-full. On a flush it redirects, and any in-flight ICache response from the squashed path is discarded.

## Interface
- RESET_PC, 32'hBFC0_0000, fetch PC loaded on reset
- LINE_WORDS, 8, ICache line size in 32-bit words; must be a power of two ≥ 2
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  redirect request; highest priority
- flush_pc_i  in  32  redirect target; bits [1:0] ignored and forced to 0
- buffer_full_i  in  1  instruction buffer cannot accept a pair
- icache_req_o  out  1  fetch request
- icache_pc_o  out  32  address of the first word of the request
- icache_ack_i  in  1  ICache accepts the request this cycle; meaningful only when icache_req_o=1
- icache_resp_valid_i  in  1  response for the outstanding request
- icache_inst1_i, icache_inst2_i  in  32 each  instructions at pc and pc+4
- inst1_o, inst2_o  out  32 each  instructions to the buffer
- inst1_addr_o, inst2_addr_o  out  32 each  their addresses
- inst1_valid_o, inst2_valid_o  out  1 each  push strobes to the buffer
- discard_cnt_o  out  16  number of squashed responses; saturating

## Operation
- States: IDLE, REQ, WAIT, DISCARD. All state is held in registers; outputs are combinational from state and inputs.
- Reset: state=IDLE, pc=RESET_PC, discard_cnt=0.
  - All outputs are 0 during the reset cycle and while in IDLE, except icache_pc_o, which equals pc.
- IDLE → REQ unconditionally on the next cycle.
- REQ:
  - icache_req_o = !buffer_full_i && !flush_i; icache_pc_o = pc.
  - If req && ack → WAIT.
  - Otherwise stay in REQ; the request may drop and re-raise freely.
- WAIT:
  - While icache_resp_valid_i=1 and flush_i=0:
    - inst1_valid_o=1.
    - inst2_valid_o=1 unless pc[log2(LINE_WORDS)+1:2] is all ones (last word of the line); the second word then belongs to the next line.
    - inst1_addr_o=pc, inst2_addr_o=pc+4; inst data passes through from the ICache.
    - Next cycle: pc += 8 if two instructions were valid, else pc += 4; state → REQ.
  - No response → stay in WAIT.
- Flush (any state except during rst; flush has priority over everything but rst):
  - pc <= {flush_pc_i[31:2],2'b00}; both inst valids are forced to 0 this cycle.
  - From WAIT without a same-cycle response → DISCARD.
  - From WAIT with a same-cycle response → response dropped, discard_cnt++, → REQ.
  - From REQ or IDLE → REQ. No request was accepted because req is gated by flush.
  - From DISCARD → stay in DISCARD with the new pc. A same-cycle response counts as the awaited one: discard_cnt++, → REQ.
- DISCARD:
  - icache_req_o=0, valids=0.
  - On icache_resp_valid_i: discard_cnt++ (saturates at 16'hFFFF) → REQ.
- Arithmetic: pc is 32-bit and wraps modulo 2^32 (pc=0xFFFF_FFF8 +8 → 0). The addr+4 output also wraps.
- buffer_full_i is sampled only at request issue. A response already in flight is always forwarded; the buffer guarantees room for one in-flight pair.

## Timing
- Request-to-push latency equals ICache latency; this block adds 0 cycles (response forwarding is combinational).
- Back-to-back fetch: response in cycle N; a new request can be accepted in cycle N+1 at the updated pc. Peak rate is one pair per 2 cycles with a 1-cycle ICache.
- A flush in cycle N produces a request at flush_pc in cycle N+1, or after the stale response arrives if in DISCARD.
- rst mid-WAIT/DISCARD: the state machine returns to IDLE and the in-flight response is not discarded by this block. The ICache is reset by the same rst.

## Test plan
- Reset, then 1-cycle ICache: req at cycle 2 with pc 0xBFC00000; response → both valids, addrs 0xBFC00000/0xBFC00004; next req pc 0xBFC00008.
- pc 0xBFC0001C (last word, LINE_WORDS=8): response → inst1_valid=1, inst2_valid=0; next req pc 0xBFC00020.
- buffer_full_i=1 while in REQ for 5 cycles → icache_req_o=0 throughout; deassert → req in the same cycle, still at the same pc.
- Ack at pc 0x100, flush_i with 0x2003 before the response (ICache latency 3) → DISCARD, no req. Stale response → valids 0, discard_cnt=1; next cycle req pc 0x2000.
- Flush coincident with a response → valids 0, discard_cnt+1, next-cycle req at the flush pc. Flush while in REQ → no ack and no discard.
- rst asserted in WAIT → next cycle IDLE, pc=RESET_PC, discard_cnt=0, all valids 0. pc=0xFFFFFFF8 two-inst response → next pc 0x00000000.
